chan_err_inj: RTL and testbench

Parametrised channel-impairment stage sitting between the convolutional encoder and the Viterbi decoder in the tx/rx test harness. Passes W-bit code symbols through one register stage and flips selected bit lanes according to a run-time mode: clean, periodic single error, periodic burst, or pseudo-random at a programmable rate. Keeps saturating counts of symbols passed and bits corrupted, so benches can measure decoder bit error rate (BER) against a known injected error count.

---
 rtl/chan_pkg.sv | 33 +++
 rtl/chan_err_inj_if.sv | 28 ++
 rtl/chan_err_inj_lfsr16.sv | 27 ++
 rtl/chan_err_inj.sv | 131 +++++++++++++
 tb/tb_chan_err_inj.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/chan_pkg.sv
// Shared types and helpers for the channel error-injection stage.
// Holds the mode/state enums, the LFSR tap mask and a width-bounded popcount.
package chan_pkg;

  typedef enum logic [1:0] {
    CLEAN    = 2'd0,
    PERIODIC = 2'd1,
    BURST    = 2'd2,
    RANDOM   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    HIT  = 2'd2
  } state_e;

  // Taps 16,14,13,11 expressed as a mask over bits [15:0].
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int POP_W = 32;

  // Counts set bits among the low w bits; callers pass their symbol width W.
  function automatic int unsigned popcount(input logic [POP_W-1:0] v, input int w);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_W; i++) begin
      if (i < w && v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/chan_err_inj_if.sv
// Symbol stream, control and statistics bundle between the harness and chan_err_inj.
// master drives symbols/controls; slave is the impairment stage.
interface chan_err_inj_if #(
  parameter int W     = 2,
  parameter int CNT_W = 16
);
  logic [1:0]       mode_i;
  logic [W-1:0]     mask_i;
  logic [7:0]       thresh_i;
  logic             clr_i;
  logic             valid_i;
  logic [W-1:0]     sym_i;
  logic             valid_o;
  logic [W-1:0]     sym_o;
  logic             err_o;
  logic [CNT_W-1:0] sym_ct_o;
  logic [CNT_W-1:0] err_bits_o;

  modport master (
    output mode_i, mask_i, thresh_i, clr_i, valid_i, sym_i,
    input  valid_o, sym_o, err_o, sym_ct_o, err_bits_o
  );

  modport slave (
    input  mode_i, mask_i, thresh_i, clr_i, valid_i, sym_i,
    output valid_o, sym_o, err_o, sym_ct_o, err_bits_o
  );
endinterface

// File: rtl/chan_err_inj_lfsr16.sv
// 16-bit Fibonacci LFSR, shifting left with feedback into bit 0.
// Advances only when step_i is high so the sequence tracks valid symbols.
module lfsr16
  import chan_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step_i,
  output logic [15:0] q_o
);

  logic [15:0] r_q;
  logic        w_fb;

  assign w_fb = ^(r_q & LFSR_TAPS);

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_q <= SEED;
    else if (step_i) r_q <= {r_q[14:0], w_fb};
  end

  assign q_o = r_q;

endmodule

// File: rtl/chan_err_inj.sv
// Channel impairment stage: registers W-bit code symbols and flips masked lanes
// in clean / periodic single / periodic burst / pseudo-random modes, with stats.
module chan_err_inj
  import chan_pkg::*;
#(
  parameter int          W      = 2,
  parameter int          PERIOD = 16,
  parameter int          BURST  = 2,
  parameter int          CNT_W  = 16,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input logic           clk,
  input logic           rst,
  chan_err_inj_if.slave bus
);

  localparam int             PH_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [PH_W-1:0] LAST   = PH_W'(PERIOD - 1);
  localparam logic [PH_W-1:0] START2 = PH_W'(PERIOD - BURST);

  mode_e            r_mode;
  state_e           r_state;
  logic [PH_W-1:0]  r_phase;
  logic             r_valid;
  logic             r_err;
  logic [W-1:0]     r_sym;
  logic [CNT_W-1:0] r_sym_ct;
  logic [CNT_W-1:0] r_err_bits;

  mode_e            w_mode;
  logic             w_mode_chg;
  logic             w_periodic;
  logic [PH_W-1:0]  w_start;
  logic [PH_W-1:0]  w_phase;
  logic [PH_W-1:0]  w_phase_nxt;
  state_e           w_state;
  state_e           w_state_nxt;
  logic             w_inj;
  logic [15:0]      w_lfsr;
  logic [W-1:0]     w_flip;
  logic [CNT_W:0]   w_pop;
  logic [CNT_W:0]   w_err_sum;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .step_i (bus.valid_i),
    .q_o    (w_lfsr)
  );

  assign w_mode     = mode_e'(bus.mode_i);
  assign w_mode_chg = (w_mode != r_mode);
  assign w_periodic = (w_mode == PERIODIC) || (w_mode == BURST);
  assign w_start    = (w_mode == BURST) ? START2 : LAST;
  // A mode change restarts the frame in the same cycle, so that symbol is phase 0.
  assign w_phase    = w_mode_chg ? '0 : r_phase;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    w_state     = r_state;
    w_state_nxt = IDLE;
    w_inj       = 1'b0;
    w_phase_nxt = w_phase;

    if (!w_periodic)                        w_state = IDLE;
    else if (w_mode_chg || r_state == IDLE) w_state = (w_phase >= w_start) ? HIT : GAP;

    case (w_mode)
      PERIODIC, BURST: w_inj = (w_state == HIT);
      RANDOM:          w_inj = (w_lfsr[7:0] < bus.thresh_i);
      default:         w_inj = 1'b0;
    endcase

    if (bus.valid_i) w_phase_nxt = (w_phase == LAST) ? '0 : w_phase + 1'b1;

    case (w_state)
      GAP:     w_state_nxt = (w_phase_nxt >= w_start) ? HIT : GAP;
      HIT:     w_state_nxt = (w_phase_nxt <  w_start) ? GAP : HIT;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode  <= CLEAN;
      r_state <= IDLE;
      r_phase <= '0;
    end else begin
      r_mode  <= w_mode;
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  assign w_flip    = bus.mask_i & {W{w_inj}};
  assign w_pop     = (CNT_W+1)'(popcount(POP_W'(w_flip), W));
  assign w_err_sum = {1'b0, r_err_bits} + w_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_sym   <= '0;
    end else begin
      r_valid <= bus.valid_i;
      r_err   <= bus.valid_i & w_inj;
      if (bus.valid_i) r_sym <= bus.sym_i ^ w_flip;
    end
  end

  // Clear beats a coincident valid symbol; both counters stick at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sym_ct   <= '0;
      r_err_bits <= '0;
    end else if (bus.clr_i) begin
      r_sym_ct   <= '0;
      r_err_bits <= '0;
    end else if (bus.valid_i) begin
      if (r_sym_ct != '1) r_sym_ct <= r_sym_ct + 1'b1;
      r_err_bits <= w_err_sum[CNT_W] ? '1 : w_err_sum[CNT_W-1:0];
    end
  end

  assign bus.valid_o    = r_valid;
  assign bus.err_o      = r_err;
  assign bus.sym_o      = r_sym;
  assign bus.sym_ct_o   = r_sym_ct;
  assign bus.err_bits_o = r_err_bits;

endmodule

// File: tb/tb_chan_err_inj.sv
// Directed bench for chan_err_inj: expected values are hand-derived from frame
// positions, plus a reference LFSR for the random mode.
module tb_chan_err_inj;

  localparam int          W      = 2;
  localparam int          PERIOD = 16;
  localparam int          BURST  = 2;
  localparam int          CNT_W  = 16;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  chan_err_inj_if #(.W(W), .CNT_W(CNT_W)) bus ();
  chan_err_inj_if #(.W(W), .CNT_W(4))     sbus ();

  chan_err_inj #(.W(W), .PERIOD(PERIOD), .BURST(BURST), .CNT_W(CNT_W), .SEED(SEED)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  chan_err_inj #(.W(W), .PERIOD(PERIOD), .BURST(BURST), .CNT_W(4), .SEED(SEED)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  assign sbus.mode_i   = bus.mode_i;
  assign sbus.mask_i   = bus.mask_i;
  assign sbus.thresh_i = bus.thresh_i;
  assign sbus.clr_i    = bus.clr_i;
  assign sbus.valid_i  = bus.valid_i;
  assign sbus.sym_i    = bus.sym_i;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge with outputs settled.
  task automatic send(input logic v, input logic [W-1:0] s);
    bus.valid_i = v;
    bus.sym_i   = s;
    @(posedge clk);
    @(negedge clk);
    bus.valid_i = 1'b0;
    bus.clr_i   = 1'b0;
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] s;
    logic [W-1:0] exp_sym;
    logic         e;
    logic [15:0]  m_lfsr;
    int           err_seen;

    rst          = 1'b0;
    bus.mode_i   = 2'd0;
    bus.mask_i   = '0;
    bus.thresh_i = 8'd0;
    bus.clr_i    = 1'b0;
    bus.valid_i  = 1'b0;
    bus.sym_i    = '0;
    exp_sym      = '0;

    // Reset state
    #1;
    check("rst_valid_o",  bus.valid_o,    0);
    check("rst_sym_o",    bus.sym_o,      0);
    check("rst_err_o",    bus.err_o,      0);
    check("rst_sym_ct",   bus.sym_ct_o,   0);
    check("rst_err_bits", bus.err_bits_o, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Mode 0: clean pass-through even with a full mask
    bus.mask_i = 2'b11;
    for (int k = 0; k < 64; k++) begin
      s = W'($urandom);
      send(1'b1, s);
      exp_sym = s;
      check("m0_sym",   bus.sym_o,   s);
      check("m0_err",   bus.err_o,   0);
      check("m0_valid", bus.valid_o, 1);
    end
    check("m0_sym_ct",     bus.sym_ct_o,    64);
    check("m0_err_bits",   bus.err_bits_o,  0);
    check("sat_sym_ct",    sbus.sym_ct_o,   15);
    check("sat_err_bits0", sbus.err_bits_o, 0);
    send(1'b0, ~exp_sym);
    check("idle_valid", bus.valid_o, 0);
    check("idle_err",   bus.err_o,   0);
    check("idle_hold",  bus.sym_o,   exp_sym);

    // Mode 1: single flip of lane 0 on the last symbol of each 16-symbol frame
    bus.clr_i = 1'b1;
    send(1'b0, '0);
    check("clr_idle_sym_ct", bus.sym_ct_o, 0);
    bus.mode_i = 2'd1;
    bus.mask_i = 2'b01;
    for (int k = 0; k < 256; k++) begin
      s = W'($urandom);
      e = ((k % 16) == 15);
      send(1'b1, s);
      exp_sym = s ^ {1'b0, e};
      check("m1_sym", bus.sym_o, exp_sym);
      check("m1_err", bus.err_o, e);
    end
    check("m1_sym_ct",   bus.sym_ct_o,   256);
    check("m1_err_bits", bus.err_bits_o, 16);

    // Mode 2: both lanes flipped on symbols 14 and 15 of each frame, random idle gaps
    bus.clr_i = 1'b1;
    send(1'b0, ~exp_sym);
    bus.mode_i = 2'd2;
    bus.mask_i = 2'b11;
    for (int k = 0; k < 256; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        send(1'b0, ~exp_sym);
        check("m2_gap_valid", bus.valid_o, 0);
        check("m2_gap_err",   bus.err_o,   0);
        check("m2_gap_hold",  bus.sym_o,   exp_sym);
      end
      s = W'($urandom);
      e = ((k % 16) >= 14);
      send(1'b1, s);
      exp_sym = s ^ {e, e};
      check("m2_sym", bus.sym_o, exp_sym);
      check("m2_err", bus.err_o, e);
    end
    check("m2_sym_ct",    bus.sym_ct_o,    256);
    check("m2_err_bits",  bus.err_bits_o,  64);
    check("sat_sym_ct2",  sbus.sym_ct_o,   15);
    check("sat_err_bits", sbus.err_bits_o, 15);

    // Mode change 2 -> 1 at phase 10: new frame starts on the switching symbol
    for (int j = 0; j < 10; j++) begin
      send(1'b1, 2'b00);
      check("pre_switch_err", bus.err_o, 0);
    end
    bus.mode_i = 2'd1;
    bus.mask_i = 2'b01;
    for (int j = 0; j < 20; j++) begin
      send(1'b1, 2'b00);
      check("switch_err", bus.err_o, (j == 15));
    end

    // Reset while the burst FSM is in HIT
    bus.mode_i = 2'd2;
    bus.mask_i = 2'b11;
    for (int j = 0; j < 15; j++) begin
      send(1'b1, 2'b00);
      check("hit_err", bus.err_o, (j == 14));
    end
    check("hit_sym", bus.sym_o, 2'b11);
    rst = 1'b0;
    #1;
    check("mid_rst_valid",    bus.valid_o,    0);
    check("mid_rst_sym",      bus.sym_o,      0);
    check("mid_rst_err",      bus.err_o,      0);
    check("mid_rst_sym_ct",   bus.sym_ct_o,   0);
    check("mid_rst_err_bits", bus.err_bits_o, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // LFSR back at SEED: low byte 0xE1 injects only for thresh above 225
    bus.mode_i   = 2'd3;
    bus.mask_i   = 2'b01;
    bus.thresh_i = 8'd226;
    send(1'b1, 2'b10);
    check("seed_err", bus.err_o, 1);
    check("seed_sym", bus.sym_o, 2'b11);
    m_lfsr = lfsr_next(SEED);
    bus.thresh_i = 8'd225;
    e = (m_lfsr[7:0] < 8'd225);
    send(1'b1, 2'b10);
    check("seed2_err", bus.err_o, e);
    m_lfsr = lfsr_next(m_lfsr);

    // Mode 3 at rate 128 against the reference LFSR
    bus.thresh_i = 8'd128;
    for (int k = 0; k < 200; k++) begin
      s = W'($urandom);
      e = (m_lfsr[7:0] < 8'd128);
      m_lfsr = lfsr_next(m_lfsr);
      send(1'b1, s);
      check("rnd_err", bus.err_o, e);
      check("rnd_sym", bus.sym_o, s ^ {1'b0, e});
    end

    // Mode 3 with thresh 0 never injects
    bus.clr_i    = 1'b1;
    send(1'b0, '0);
    bus.thresh_i = 8'd0;
    err_seen     = 0;
    for (int k = 0; k < 1000; k++) begin
      send(1'b1, W'($urandom));
      if (bus.err_o !== 1'b0) err_seen++;
    end
    check("thr0_err_seen", err_seen,         0);
    check("thr0_err_bits", bus.err_bits_o,   0);
    check("thr0_sym_ct",   bus.sym_ct_o,     1000);

    // After reset the burst waits for a full gap
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.mode_i = 2'd2;
    bus.mask_i = 2'b11;
    for (int j = 0; j < 16; j++) begin
      send(1'b1, 2'b01);
      check("post_rst_err", bus.err_o, (j >= 14));
    end

    // Clear coincident with a corrupted valid symbol
    for (int j = 0; j < 14; j++) send(1'b1, 2'b00);
    check("pre_clr_sym_ct", bus.sym_ct_o, 30);
    bus.clr_i = 1'b1;
    send(1'b1, 2'b01);
    check("clr_valid",    bus.valid_o,    1);
    check("clr_sym",      bus.sym_o,      2'b10);
    check("clr_err",      bus.err_o,      1);
    check("clr_sym_ct",   bus.sym_ct_o,   0);
    check("clr_err_bits", bus.err_bits_o, 0);
    send(1'b1, 2'b00);
    check("post_clr_sym_ct",   bus.sym_ct_o,   1);
    check("post_clr_err_bits", bus.err_bits_o, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
